vecmac_acc_collector: RTL and testbench

- Sink-side partner of the int8 vector MAC datapath. It consumes the fixed-latency result stream (mac_valid/mac_sum) of the 4-lane multiplier/adder-tree pipeline.
- Accumulates cfg_len consecutive 18-bit partial sums into one ACC_W-bit dot-product result, queues finished results in a small FIFO and offers them downstream over valid/ready.
- The multiplier pipeline cannot stall, so the block also issues credits (issue_ready) to the operand issuer. Every started dot product is guaranteed a FIFO slot before its first beat enters the pipeline.

---
 rtl/vecmac_acc_collector.sv | 170 +++++++++++++++++
 tb/tb_vecmac_acc_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vecmac_acc_collector.sv
// rtl/vecmac_acc_collector.sv - dot-product accumulator, result FIFO and issue credits for the int8 vector MAC
// Optional feature macro: VECMAC_ACC_SAT_EN (saturate overflowed results to all-ones)

module vecmac_acc_collector #(
  parameter int ACC_W      = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             mac_valid,
  input  logic [17:0]      mac_sum,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data,
  output logic             m_ovf,
  output logic             busy,
  output logic             err
);

  localparam int SLOT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // Enough headroom for every beat of every reserved dot product to be in flight.
  localparam int OUT_W  = LEN_W + SLOT_W;

  // Issue-side state
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [SLOT_W-1:0] slots_used_q, slots_used_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;

  // Receive-side state
  logic [LEN_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;

  // Result FIFO state
  logic [ACC_W-1:0]  mem_data_q [FIFO_DEPTH];
  logic [ACC_W-1:0]  mem_data_d [FIFO_DEPTH];
  logic              mem_ovf_q  [FIFO_DEPTH];
  logic              mem_ovf_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SLOT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic              err_q, err_d;

  // Combinational helpers
  logic [LEN_W-1:0]  len_m1;
  logic              issue_fire;
  logic              reserve;
  logic              pop;
  logic              mac_accept;
  logic              stale_beat;
  logic              last_beat;
  logic              fifo_full;
  logic              push_ok;
  logic              push_drop;
  logic [ACC_W-1:0]  acc_base;
  logic              ovf_base;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  acc_next;
  logic              ovf_next;
  logic [ACC_W-1:0]  res_data;

  // A new dot product may only start when a FIFO slot is free; continuation beats always pass.
  assign issue_ready = !((issue_cnt_q == '0) && (slots_used_q == SLOT_W'(FIFO_DEPTH)));
  assign m_valid     = (fifo_cnt_q != '0);
  assign m_data      = mem_data_q[rd_ptr_q];
  assign m_ovf       = mem_ovf_q[rd_ptr_q];
  assign busy        = (issue_cnt_q != '0) || (slots_used_q != '0);
  assign err         = err_q;

  // Credit accounting, beat accumulation and FIFO push/pop bookkeeping.
  always_comb begin
    len_m1        = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);

    issue_fire    = issue_valid && issue_ready;
    reserve       = issue_fire && (issue_cnt_q == '0);
    pop           = m_valid && m_ready;

    issue_cnt_d   = issue_cnt_q;
    if (issue_fire) begin
      issue_cnt_d = (issue_cnt_q == len_m1) ? '0 : issue_cnt_q + LEN_W'(1);
    end
    slots_used_d  = slots_used_q + SLOT_W'(reserve) - SLOT_W'(pop);

    // A beat with nothing in flight cannot belong to any issued dot product.
    mac_accept    = mac_valid && (outstanding_q != '0);
    stale_beat    = mac_valid && (outstanding_q == '0);
    outstanding_d = outstanding_q + OUT_W'(issue_fire) - OUT_W'(mac_accept);

    acc_base      = (rx_cnt_q == '0) ? '0 : acc_q;
    ovf_base      = (rx_cnt_q == '0) ? 1'b0 : ovf_q;
    sum_ext       = {1'b0, acc_base} + (ACC_W + 1)'(mac_sum);
    acc_next      = sum_ext[ACC_W-1:0];
    ovf_next      = ovf_base | sum_ext[ACC_W];
`ifdef VECMAC_ACC_SAT_EN
    res_data      = ovf_next ? '1 : acc_next;
`else
    res_data      = acc_next;
`endif

    last_beat     = mac_accept && (rx_cnt_q == len_m1);

    rx_cnt_d      = rx_cnt_q;
    acc_d         = acc_q;
    ovf_d         = ovf_q;
    if (mac_accept) begin
      rx_cnt_d    = last_beat ? '0 : rx_cnt_q + LEN_W'(1);
      acc_d       = acc_next;
      ovf_d       = ovf_next;
    end

    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    fifo_full     = (fifo_cnt_q == SLOT_W'(FIFO_DEPTH));
    push_ok       = last_beat && (!fifo_full || pop);
    push_drop     = last_beat && fifo_full && !pop;

    mem_data_d    = mem_data_q;
    mem_ovf_d     = mem_ovf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (push_ok) begin
      mem_data_d[wr_ptr_q] = res_data;
      mem_ovf_d[wr_ptr_q]  = ovf_next;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    end
    fifo_cnt_d    = fifo_cnt_q + SLOT_W'(push_ok) - SLOT_W'(pop);

    err_d         = err_q || stale_beat || push_drop;
  end

  // State registers; reset clears counters, accumulator and FIFO contents so m_data reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q   <= '0;
      slots_used_q  <= '0;
      outstanding_q <= '0;
      rx_cnt_q      <= '0;
      acc_q         <= '0;
      ovf_q         <= 1'b0;
      mem_data_q    <= '{default: '0};
      mem_ovf_q     <= '{default: 1'b0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      slots_used_q  <= slots_used_d;
      outstanding_q <= outstanding_d;
      rx_cnt_q      <= rx_cnt_d;
      acc_q         <= acc_d;
      ovf_q         <= ovf_d;
      mem_data_q    <= mem_data_d;
      mem_ovf_q     <= mem_ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_vecmac_acc_collector.sv
// tb/tb_vecmac_acc_collector.sv - scoreboard bench for vecmac_acc_collector (32-bit and 18-bit instances)

module tb_vecmac_acc_collector;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_len;
  logic        issue_valid;
  logic        mac_valid;
  logic [17:0] mac_sum;
  logic        m_ready;

  logic        issue_ready_a, m_valid_a, m_ovf_a, busy_a, err_a;
  logic [31:0] m_data_a;
  logic        issue_ready_b, m_valid_b, m_ovf_b, busy_b, err_b;
  logic [17:0] m_data_b;

  int checks;
  int errors;

  logic [32:0] exp_a [$];
  logic [18:0] exp_b [$];

`ifdef VECMAC_ACC_SAT_EN
  localparam logic [17:0] B_OVF_DATA = 18'h3FFFF;
`else
  localparam logic [17:0] B_OVF_DATA = 18'h0F605;
`endif

  vecmac_acc_collector #(.ACC_W(32), .LEN_W(8), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .issue_valid(issue_valid), .issue_ready(issue_ready_a),
    .mac_valid(mac_valid), .mac_sum(mac_sum),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_ovf(m_ovf_a),
    .busy(busy_a), .err(err_a)
  );

  vecmac_acc_collector #(.ACC_W(18), .LEN_W(8), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .issue_valid(issue_valid), .issue_ready(issue_ready_b),
    .mac_valid(mac_valid), .mac_sum(mac_sum),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_ovf(m_ovf_b),
    .busy(busy_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] da, input logic oa, input logic [17:0] db, input logic ob);
    exp_a.push_back({oa, da});
    exp_b.push_back({ob, db});
  endtask

  task automatic issue_beats(input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid = 1'b1;
      step();
    end
    issue_valid = 1'b0;
  endtask

  task automatic mac_beats(input int n, input logic [17:0] s);
    for (int i = 0; i < n; i++) begin
      mac_valid = 1'b1;
      mac_sum   = s;
      step();
    end
    mac_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted result of either instance.
  initial begin
    logic [32:0] ea;
    logic [18:0] eb;
    forever begin
      @(negedge clk);
      if (!rst && m_ready) begin
        if (m_valid_a) begin
          if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_a_unexpected actual=%0h expected=none", m_data_a);
          end else begin
            ea = exp_a.pop_front();
            chk("mon_a_data", m_data_a, ea[31:0]);
            chk("mon_a_ovf", m_ovf_a, ea[32]);
          end
        end
        if (m_valid_b) begin
          if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_b_unexpected actual=%0h expected=none", m_data_b);
          end else begin
            eb = exp_b.pop_front();
            chk("mon_b_data", m_data_b, eb[17:0]);
            chk("mon_b_ovf", m_ovf_b, eb[18]);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cfg_len = 8'd0;
    issue_valid = 1'b0;
    mac_valid = 1'b0;
    mac_sum = '0;
    m_ready = 1'b0;
    step();
    step();
    chk("rst_issue_ready", issue_ready_a, 1);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_m_ovf", m_ovf_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    rst = 1'b0;
    step();

    // Four-beat dot product 1+2+3+4 with single-cycle result latency.
    cfg_len = 8'd4;
    m_ready = 1'b1;
    push_exp(32'd10, 1'b0, 18'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_issue_ready", issue_ready_a, 1);
      issue_valid = 1'b1;
      step();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mac_valid = 1'b1;
      mac_sum = 18'(i + 1);
      if (i == 3) chk("t1_mvalid_before", m_valid_a, 0);
      step();
    end
    mac_valid = 1'b0;
    chk("t1_mvalid_after", m_valid_a, 1);
    step();
    chk("t1_mvalid_clear", m_valid_a, 0);
    chk("t1_busy_clear", busy_a, 0);

    // cfg_len of zero behaves as a single beat.
    cfg_len = 8'd0;
    push_exp(32'hFE01, 1'b0, 18'hFE01, 1'b0);
    issue_beats(1);
    mac_beats(1, 18'hFE01);
    step();

    // Credit exhaustion with a stalled consumer, then one credit per pop.
    cfg_len = 8'd1;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_exp(32'(8'h11 * i), 1'b0, 18'(8'h11 * i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      issue_valid = (i < 4);
      mac_valid = (i > 0);
      mac_sum = 18'(8'h11 * i);
      if (i < 4) chk("t3_issue_ready", issue_ready_a, 1);
      step();
    end
    issue_valid = 1'b0;
    mac_valid = 1'b0;
    chk("t3_credit_closed", issue_ready_a, 0);
    chk("t3_busy", busy_a, 1);
    chk("t3_m_valid", m_valid_a, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t3_credit_reopen", issue_ready_a, 1);
    issue_beats(1);
    chk("t3_one_credit", issue_ready_a, 0);
    mac_beats(1, 18'h55);
    m_ready = 1'b1;
    repeat (5) step();
    chk("t3_drained", m_valid_a, 0);
    chk("t3_err", err_a, 0);

    // Push and pop in the same cycle with two results held.
    m_ready = 1'b0;
    push_exp(32'h101, 1'b0, 18'h101, 1'b0);
    push_exp(32'h202, 1'b0, 18'h202, 1'b0);
    push_exp(32'h303, 1'b0, 18'h303, 1'b0);
    issue_valid = 1'b1;
    step();
    mac_valid = 1'b1; mac_sum = 18'h101;
    step();
    mac_sum = 18'h202;
    step();
    issue_valid = 1'b0;
    mac_sum = 18'h303;
    m_ready = 1'b1;
    step();
    mac_valid = 1'b0;
    m_ready = 1'b0;
    chk("t5_m_valid", m_valid_a, 1);
    chk("t5_err", err_a, 0);
    chk("t5_issue_ready", issue_ready_a, 1);
    m_ready = 1'b1;
    step();
    chk("t5_one_left", m_valid_a, 1);
    step();
    chk("t5_empty", m_valid_a, 0);

    // Five beats of 0xFE01: carries out of 18 bits but not out of 32.
    cfg_len = 8'd5;
    push_exp(32'h4F605, 1'b0, B_OVF_DATA, 1'b1);
    issue_beats(5);
    mac_beats(5, 18'h0FE01);
    step();
    step();
    chk("t4_b_err", err_b, 0);
    chk("t4_b_m_valid", m_valid_b, 0);

    // Reset mid dot product, then stale pipeline beats.
    m_ready = 1'b0;
    cfg_len = 8'd4;
    issue_beats(4);
    mac_beats(2, 18'h3);
    chk("t6_busy", busy_a, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_issue_ready", issue_ready_a, 1);
    chk("t6_rst_m_valid", m_valid_a, 0);
    chk("t6_rst_m_data", m_data_a, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_err", err_a, 0);
    step();
    rst = 1'b0;
    step();
    mac_beats(3, 18'h7);
    step();
    chk("t6_err_a", err_a, 1);
    chk("t6_err_b", err_b, 1);
    chk("t6_m_valid", m_valid_a, 0);
    chk("t6_busy_after", busy_a, 0);
    chk("t6_issue_ready", issue_ready_a, 1);

    for (int i = 0; i < 50 && (exp_a.size() != 0 || exp_b.size() != 0); i++) step();
    chk("sb_a_left", 64'(exp_a.size()), 0);
    chk("sb_b_left", 64'(exp_b.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
